// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions.
//   - Opcodes the decoder and sequencer agree on, including OP_INT, the
//     opcode injected to run the interrupt sequence.
//   - Interrupt source priority encoding plus a helper that resolves the
//     winning pending source.
package cpu_pkg;

  localparam logic [7:0] OP_INT     = 8'h00;  // BRK, reused as the interrupt sequence
  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_RTS     = 8'h60;

  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_CLR  = 2'd1,
    PRI_NMI  = 2'd2,
    PRI_IRQ  = 2'd3
  } pri_e;

  // Highest-priority pending source: reset beats NMI beats IRQ.
  function automatic pri_e int_source(input logic clr_p, input logic nmi_p,
                                      input logic irq_p);
    pri_e src;
    src = PRI_NONE;
    if (clr_p)      src = PRI_CLR;
    else if (nmi_p) src = PRI_NMI;
    else if (irq_p) src = PRI_IRQ;
    return src;
  endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Decoder-side bus of the cycle sequencer.
//   Inputs to the sequencer : rdy, inst_in, icyc, rcyc, scyc, sinst,
//                             nmi, irq, irq_en, irqdis
//   Outputs of the sequencer: inst, cycle, clr_pend, nmi_pend, irq_pend,
//                             int_id, retire, cyc_err
// slave  = the sequencer; master = the decoder / interrupt environment.
interface cycle_sequencer_if #(
  parameter int CYC_W = 3,
  parameter int IRQ_N = 1,
  parameter int ID_W  = 1
);
  logic             rdy;
  logic [7:0]       inst_in;
  logic             icyc;
  logic             rcyc;
  logic             scyc;
  logic             sinst;
  logic             nmi;
  logic [IRQ_N-1:0] irq;
  logic [IRQ_N-1:0] irq_en;
  logic             irqdis;

  logic [7:0]       inst;
  logic [CYC_W-1:0] cycle;
  logic             clr_pend;
  logic             nmi_pend;
  logic             irq_pend;
  logic [ID_W-1:0]  int_id;
  logic             retire;
  logic             cyc_err;

  modport slave (
    input  rdy, inst_in, icyc, rcyc, scyc, sinst, nmi, irq, irq_en, irqdis,
    output inst, cycle, clr_pend, nmi_pend, irq_pend, int_id, retire, cyc_err
  );

  modport master (
    output rdy, inst_in, icyc, rcyc, scyc, sinst, nmi, irq, irq_en, irqdis,
    input  inst, cycle, clr_pend, nmi_pend, irq_pend, int_id, retire, cyc_err
  );
endinterface

// File: rtl/int_latch.sv
// Interrupt request latch for the cycle sequencer.
//   clk, clr      : clock, synchronous active-high reset (sets clr_pend)
//   nmi           : edge-sensitive non-maskable request
//   irq, irq_en   : level-sensitive maskable requests and per-line enables
//   irqdis        : status I flag, masks all IRQ lines
//   sinst_ok      : qualified "interrupt sequence accepted" from the decoder
//   clr_pend, nmi_pend, irq_pend : pending flags to the decoder
//   irq_id        : lowest enabled active IRQ line, registered with irq_pend
import cpu_pkg::*;

module int_latch #(
  parameter int IRQ_N = 1,
  parameter int ID_W  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             nmi,
  input  logic [IRQ_N-1:0] irq,
  input  logic [IRQ_N-1:0] irq_en,
  input  logic             irqdis,
  input  logic             sinst_ok,
  output logic             clr_pend,
  output logic             nmi_pend,
  output logic             irq_pend,
  output logic [ID_W-1:0]  irq_id
);

  logic             nmi_q;
  logic             nmi_edge;
  logic [IRQ_N-1:0] irq_act;
  logic [ID_W-1:0]  low_id;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    irq_act  = irq & irq_en;
    nmi_edge = nmi & ~nmi_q;
    low_id   = '0;
    // Scan downwards so the lowest active index is the last one written.
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq_act[i]) low_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      clr_pend <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_q    <= 1'b0;
      irq_pend <= 1'b0;
      irq_id   <= '0;
    end else begin
      nmi_q    <= nmi;
      // IRQ is a plain registered level: dropping the line withdraws it.
      irq_pend <= (|irq_act) & ~irqdis;
      irq_id   <= low_id;

      // sinst clears only the winning source; IRQ is left to irqdis.
      if (sinst_ok && clr_pend) clr_pend <= 1'b0;

      // A fresh edge always wins over the clear, so an NMI arriving during
      // its own sequence is re-entered afterwards rather than lost.
      if (nmi_edge)                   nmi_pend <= 1'b1;
      else if (sinst_ok && !clr_pend) nmi_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Cycle sequencer: sequential companion to the 6502 instruction decoder.
//   clk  : system clock
//   clr  : synchronous active-high reset; also requests the reset sequence
//   bus  : cycle_sequencer_if.slave carrying the decoder strobes, the
//          interrupt inputs, and inst/cycle/pending/int_id/retire/cyc_err
// Owns the instruction register and cycle counter, injects OP_INT at
// instruction boundaries while an interrupt is pending, and forces a fetch
// (flagging cyc_err) when the counter would run past MAX_CYC.
import cpu_pkg::*;

module cycle_sequencer #(
  parameter int CYC_W   = 3,
  parameter int MAX_CYC = 7,
  parameter int IRQ_N   = 1,
  parameter int ID_W    = 1
) (
  input logic            clk,
  input logic            clr,
  cycle_sequencer_if.slave bus
);

  // One extra bit so cycle+2 at full width is seen as an overrun, not a wrap.
  localparam logic [CYC_W:0] MAX_EXT = (CYC_W + 1)'(MAX_CYC);
  localparam logic [CYC_W:0] ONE     = (CYC_W + 1)'(1);
  localparam logic [CYC_W:0] TWO     = (CYC_W + 1)'(2);

  logic [CYC_W:0]   cyc_ext;
  logic [CYC_W:0]   step;
  logic [CYC_W-1:0] cycle_d;
  logic             overrun;
  logic             fetch;
  logic             sinst_ok;
  logic [ID_W-1:0]  irq_id;
  pri_e             src;

  int_latch #(
    .IRQ_N (IRQ_N),
    .ID_W  (ID_W)
  ) u_int_latch (
    .clk      (clk),
    .clr      (clr),
    .nmi      (bus.nmi),
    .irq      (bus.irq),
    .irq_en   (bus.irq_en),
    .irqdis   (bus.irqdis),
    .sinst_ok (sinst_ok),
    .clr_pend (bus.clr_pend),
    .nmi_pend (bus.nmi_pend),
    .irq_pend (bus.irq_pend),
    .irq_id   (irq_id)
  );

  always_comb begin
    cyc_ext = {1'b0, bus.cycle};
    step    = cyc_ext;
    // Strobe priority rcyc > scyc > icyc; rcyc overrides step via fetch.
    if (bus.scyc)      step = cyc_ext + TWO;
    else if (bus.icyc) step = cyc_ext + ONE;
    overrun  = !bus.rcyc && (bus.scyc || bus.icyc) && (step > MAX_EXT);
    fetch    = bus.rcyc || overrun;
    cycle_d  = fetch ? '0 : step[CYC_W-1:0];
    // The decoder only accepts the sequence on cycle 0 of an injected opcode.
    sinst_ok = bus.rdy && bus.sinst && (bus.cycle == '0) && (bus.inst == OP_INT);
    src      = int_source(bus.clr_pend, bus.nmi_pend, bus.irq_pend);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.cycle   <= '0;
      bus.inst    <= OP_INT;
      bus.int_id  <= '0;
      bus.retire  <= 1'b0;
      bus.cyc_err <= 1'b0;
    end else begin
      bus.retire <= 1'b0;
      if (bus.rdy) begin
        bus.cycle <= cycle_d;
        if (overrun) bus.cyc_err <= 1'b1;
        if (fetch) begin
          bus.retire <= 1'b1;
          bus.inst   <= (src == PRI_NONE) ? bus.inst_in : OP_INT;
          if (src == PRI_IRQ) bus.int_id <= irq_id;
        end
      end
    end
  end

endmodule
